// File: rtl/conv1_frame_ctrl.sv
// Frame sequencer for conv layer 1: clears the line buffer, streams a 1-bit image gap-free, counts outputs.
// Optional macro CONV1_CTRL_PERF_EN adds a frame_cycles busy-cycle counter output.
module conv1_frame_ctrl #(
    parameter int WIDTH         = 28,
    parameter int HEIGHT        = 28,
    parameter int K             = 3,
    parameter int ADDR_W        = 10,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_data,
    output logic              conv_clr,
    output logic              conv_data,
    input  logic              conv_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [9:0]        out_cnt
`ifdef CONV1_CTRL_PERF_EN
    ,
    output logic [15:0]       frame_cycles
`endif
);

    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int EXP    = (WIDTH - K + 1) * (HEIGHT - K + 1);
    localparam int STAGES = 2;
    localparam int TMO_W  = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [9:0]        EXP_CNT   = 10'(EXP);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [STAGES:0]   vld_pipe;  // [0] read issued, [1] pixel on memory bus, [2] conv_data valid
    logic [TMO_W-1:0]  tmo;
    logic              start_acc, abort_hit, cnt_en, drain_ok, tmo_hit;

    assign start_acc = (state == S_IDLE) && start;
    assign abort_hit = (state != S_IDLE) && abort;
    assign cnt_en    = ((state == S_FEED) || (state == S_DRAIN)) && conv_valid;
    assign drain_ok  = ~|vld_pipe[STAGES:1] && (out_cnt == EXP_CNT);
    assign tmo_hit   = (state == S_DRAIN) && !drain_ok && (tmo == TMO_LAST) && !abort;

    assign mem_rd_en = vld_pipe[0];
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE) && !err && !abort;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_FEED;
            S_FEED:  if (mem_addr == LAST_ADDR) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (drain_ok)             state_nxt = S_DONE;
                else if (tmo == TMO_LAST) state_nxt = S_IDLE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort_hit) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            vld_pipe  <= '0;
            mem_addr  <= '0;
            conv_clr  <= 1'b0;
            conv_data <= 1'b0;
            tmo       <= '0;
        end else begin
            state     <= state_nxt;
            // read strobe is registered from next state so it tracks FEED exactly
            vld_pipe  <= abort_hit ? '0 : {vld_pipe[STAGES-1:0], state_nxt == S_FEED};
            conv_data <= vld_pipe[1] && mem_rd_data && !abort_hit;
            conv_clr  <= (state_nxt == S_CLEAR) || abort_hit;
            mem_addr  <= (state == S_FEED && state_nxt == S_FEED) ? mem_addr + ADDR_W'(1) : '0;
            tmo       <= (state == S_DRAIN) ? tmo + TMO_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= '0;
            err     <= 1'b0;
        end else if (start_acc) begin
            out_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (cnt_en) begin
                // saturate at the expected count; any further pulse is an overrun
                if (out_cnt == EXP_CNT) err <= 1'b1;
                else                    out_cnt <= out_cnt + 10'd1;
            end
            if (tmo_hit) err <= 1'b1;
        end
    end

`ifdef CONV1_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            frame_cycles <= '0;
        else if (start_acc) frame_cycles <= '0;
        else if (busy)      frame_cycles <= frame_cycles + 16'd1;
    end
`endif

endmodule

// File: tb/tb_conv1_frame_ctrl.sv
// Bench for conv1_frame_ctrl: table of frame scenarios, image memory and conv layer models, pixel scoreboard.
module tb_conv1_frame_ctrl;

    localparam int NPIX = 784;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0;
    logic       mem_rd_en, mem_rd_data = 1'b0;
    logic [9:0] mem_addr;
    logic       conv_clr, conv_data, conv_valid;
    logic       busy, done, err;
    logic [9:0] out_cnt;
`ifdef CONV1_CTRL_PERF_EN
    logic [15:0] frame_cycles;
`endif

    conv1_frame_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .conv_clr(conv_clr), .conv_data(conv_data), .conv_valid(conv_valid),
        .busy(busy), .done(done), .err(err), .out_cnt(out_cnt)
`ifdef CONV1_CTRL_PERF_EN
        , .frame_cycles(frame_cycles)
`endif
    );

    always #5 clk = ~clk;

    // image memory: one-cycle read latency
    logic img [0:1023];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= img[mem_addr];

    // conv layer model: one valid pulse per completed KxK window, one cycle after the pixel arrives
    int   vlimit = 676, ovr = 0, pix, vcnt;
    logic [1:0] pp;
    logic cv_m, cv_f = 1'b0;
    assign conv_valid = cv_m | cv_f;
    always @(posedge clk or posedge rst) begin
        if (rst || conv_clr) begin
            pp <= '0; pix <= 0; vcnt <= 0; cv_m <= 1'b0;
        end else begin
            pp   <= {pp[0], mem_rd_en};
            cv_m <= 1'b0;
            if (pp[1]) begin
                pix <= pix + 1;
                if ((pix / 28) >= 2 && (pix % 28) >= (ovr != 0 ? 1 : 2) && vcnt < vlimit) begin
                    cv_m <= 1'b1;
                    vcnt <= vcnt + 1;
                end
            end
        end
    end

    typedef struct {
        int pat; int limit; int ovr; int abort_at; int restart_at; int sa;
        int exp_done; int exp_err; int exp_cnt; int exp_busy;
    } vec_t;
    vec_t vecs [8];

    int   n_chk = 0, n_pass = 0;
    logic sb [$];
    logic h1, h2;
    int   exp_addr, rd_cnt, clr_cnt, done_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // per-cycle monitor: pixel scoreboard, address sequence, pulse counters
    task automatic mon();
        logic e;
        if (h2) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin e = sb.pop_front(); chk("conv_data", conv_data, e); end
        end else chk("conv_data_idle", conv_data, 0);
        if (mem_rd_en) begin
            chk("mem_addr", mem_addr, exp_addr);
            exp_addr++; rd_cnt++;
        end
        clr_cnt  += int'(conv_clr);
        done_cnt += int'(done);
        h2 = h1; h1 = mem_rd_en;
    endtask

    task automatic load_img(input int pat);
        for (int i = 0; i < NPIX; i++)
            case (pat)
                0:       img[i] = 1'b1;
                1:       img[i] = 1'(((i / 28) + (i % 28)) & 1);
                default: img[i] = 1'($urandom_range(0, 1));
            endcase
    endtask

    task automatic run_frame(input vec_t v);
        int n, busy_cnt;
        bit ab;
        load_img(v.pat);
        vlimit = v.limit; ovr = v.ovr;
        sb.delete();
        for (int i = 0; i < NPIX; i++) sb.push_back(img[i]);
        exp_addr = 0; rd_cnt = 0; clr_cnt = 0; done_cnt = 0; h1 = 0; h2 = 0;
        @(negedge clk); mon(); start = 1'b1; abort = 1'(v.sa);
        @(negedge clk); mon(); start = 1'b0; abort = 1'b0;
        chk("clear_busy", busy, 1);
        chk("clear_pulse", conv_clr, 1);
        chk("clear_err", err, 0);
        chk("clear_out_cnt", out_cnt, 0);
        chk("clear_rd_en", mem_rd_en, 0);
        busy_cnt = 1; ab = 0; n = 0;
        while (1) begin
            @(negedge clk); mon(); start = 1'b0; abort = 1'b0;
            if (ab) begin
                chk("abort_clr", conv_clr, 1);
                chk("abort_rd_en", mem_rd_en, 0);
                chk("abort_busy", busy, 0);
                ab = 0; sb.delete();
            end
            if (!busy) break;
            busy_cnt++;
            if (mem_rd_en && mem_addr == v.abort_at) begin abort = 1'b1; ab = 1; h1 = 0; h2 = 0; end
            if (mem_rd_en && mem_addr == v.restart_at) start = 1'b1;
            if (++n > 3000) begin chk("frame_timeout", 1, 0); break; end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); mon();
            cv_f = (i < 2);
        end
        cv_f = 1'b0;
        chk("done_pulses", done_cnt, v.exp_done);
        chk("err", err, v.exp_err);
        chk("out_cnt", out_cnt, v.exp_cnt);
        chk("busy_cycles", busy_cnt, v.exp_busy);
        chk("rd_count", rd_cnt, v.abort_at >= 0 ? v.abort_at + 1 : NPIX);
        chk("clr_count", clr_cnt, v.abort_at >= 0 ? 2 : 1);
        if (v.abort_at < 0) chk("sb_empty", sb.size(), 0);
`ifdef CONV1_CTRL_PERF_EN
        chk("frame_cycles", frame_cycles, v.exp_busy);
`endif
    endtask

    initial begin
        //          pat lim ovr abort restart sa done err cnt busy
        vecs[0] = '{0, 676, 0, -1,  -1,     0, 1,   0, 676, 790};
        vecs[1] = '{1, 676, 0, -1,  -1,     0, 1,   0, 676, 790};
        vecs[2] = '{2, 676, 0, -1,  200,    0, 1,   0, 676, 790};
        vecs[3] = '{0, 600, 0, -1,  -1,     0, 0,   1, 600, 849};
        vecs[4] = '{1, 676, 0, 400, -1,     0, 0,   0, 316, 402};
        vecs[5] = '{0, 676, 0, -1,  -1,     1, 1,   0, 676, 790};
        vecs[6] = '{0, 700, 1, -1,  -1,     0, 0,   1, 676, 789};
        vecs[7] = '{1, 676, 0, -1,  -1,     0, 1,   0, 676, 790};

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_clr", conv_clr, 0);
        chk("rst_data", conv_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_out_cnt", out_cnt, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        // reset in the middle of a frame
        load_img(0); vlimit = 676; ovr = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid_busy_before", busy, 1);
        rst = 1'b1; #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd_en", mem_rd_en, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_data", conv_data, 0);
        chk("mid_rst_out_cnt", out_cnt, 0);
        done_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); done_cnt += int'(done); end
        chk("mid_rst_no_done", done_cnt, 0);
        chk("mid_rst_idle", busy, 0);

        run_frame(vecs[7]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/conv1_frame_ctrl.md
Name: conv1_frame_ctrl

Overview:
Frame sequencer for the first convolution layer. On a start request it clears the layer's line buffer, then reads a binary 28x28 image from a 1-bit image memory. It streams that image one pixel per cycle, gap-free, into the layer's data_in. It counts the layer's valid output pulses and reports done once every output position of the frame has been produced, or reports an error if the layer stalls.

Parameters:
WIDTH, 28, image width in pixels
HEIGHT, 28, image height in pixels
K, 3, convolution kernel size; expected outputs = (WIDTH-K+1)*(HEIGHT-K+1) = 676
ADDR_W, 10, image memory address width (must satisfy 2^ADDR_W >= WIDTH*HEIGHT)
DRAIN_TIMEOUT, 64, max cycles allowed in DRAIN without reaching the expected output count

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous assert, active-high
start  in  1  one-cycle frame request; honoured only in IDLE
abort  in  1  abandon the current frame; honoured in any non-IDLE state
mem_rd_en  out  1  image memory read strobe
mem_addr  out  ADDR_W  raster pixel address, row-major, 0..WIDTH*HEIGHT-1
mem_rd_data  in  1  pixel, valid exactly 1 cycle after mem_rd_en
conv_clr  out  1  active-high synchronous clear for the conv layer buffer
conv_data  out  1  pixel stream to conv layer data_in
conv_valid  in  1  valid_out_conv1 from the conv layer
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: frame completed with the correct output count
err  out  1  sticky; set on timeout or output overrun, cleared by next accepted start
out_cnt  out  10  conv_valid pulses counted in the current frame

Behaviour:
- Reset (async, rst=1): state=IDLE; mem_rd_en=0, mem_addr=0, conv_clr=0, conv_data=0, busy=0, done=0, err=0, out_cnt=0; internal pipeline valid bits cleared.
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: outputs idle, conv_data=0. start=1 -> CLEAR, out_cnt<=0, err<=0.
- CLEAR: exactly 1 cycle with conv_clr=1 -> FEED.
- FEED: mem_rd_en=1 every cycle; mem_addr steps 0..WIDTH*HEIGHT-1, one per cycle. After issuing the last address -> DRAIN.
- Pixel path: rd_en issued at cycle t; mem_rd_data sampled at t+1; conv_data registered, valid at t+2. The stream is therefore 784 consecutive cycles with no bubbles, because the conv layer shifts on every clock.
- conv_data = 0 whenever no pixel is in flight.
- out_cnt increments on every conv_valid=1 while in FEED or DRAIN. conv_valid in any other state is ignored.
- DRAIN: wait for the pipeline to empty and out_cnt == expected -> DONE.
  - Timeout counter starts at 0 on DRAIN entry. If it reaches DRAIN_TIMEOUT with out_cnt != expected: err<=1 -> IDLE, no done.
- Overrun: out_cnt would exceed expected -> err<=1; out_cnt saturates at expected. The frame still ends through DRAIN with done suppressed.
- DONE: done=1 for 1 cycle -> IDLE. out_cnt is held until the next start.
- start while busy: ignored, no error.
- abort (priority over every transition except reset): next state IDLE; drive conv_clr=1 for that one cycle; mem_rd_en<=0; in-flight pixels discarded (conv_data forced 0); done suppressed; err unchanged.
- start and abort in the same cycle in IDLE: abort has no effect, start accepted.
- Reset mid-frame: immediate return to reset values; no done pulse.

Optional Feature:
Macro CONV1_CTRL_PERF_EN.
- Defined: adds output frame_cycles (16 bits). Cleared on accepted start; increments every cycle while busy; freezes on DONE, error exit or abort; reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Reset then start pulse with all-ones image, conv layer model answering 676 valid pulses -> conv_clr high 1 cycle; mem_addr 0..783 on consecutive cycles; conv_data=1 for 784 consecutive cycles starting 3 cycles after start; done pulses once; out_cnt=676; err=0.
2. Image with checkerboard pattern -> conv_data sequence equals memory contents in raster order, with no bubbles and no repeated pixels.
3. Conv model emits only 600 valid pulses -> DRAIN_TIMEOUT=64 cycles after DRAIN entry, err=1, no done, busy falls; next start clears err.
4. abort asserted at mem_addr=400 -> next cycle state IDLE, conv_clr=1, mem_rd_en=0, conv_data=0 thereafter, no done; new start runs a full clean frame.
5. start re-pulsed during FEED and conv_valid pulsed while in IDLE -> both ignored; addresses and out_cnt unaffected.
6. With CONV1_CTRL_PERF_EN defined, run scenario 1 -> frame_cycles holds the exact start-to-DONE cycle count and is frozen until the next start.
